stream_checker: RTL and testbench
=================================

Name: stream_checker

Overview:
- Sink end of the valid/ready stream produced by the team's data generator.
- Accepts beats and checks each against an internally generated incrementing reference sequence.
- Applies a programmable backpressure pattern and flags protocol violations.
- Sits at the downstream edge of TLM/RTL co-simulation experiments, pairing with the generator as the traffic consumer and scoreboard.

Parameters:
- DW, 16, data width in bits
- DELAY, 0, idle cycles with ready_o low after every accepted beat (0 = no backpressure)
- INIT, 0, first expected data value (DW bits)
- CW, 32, width of the beat and error counters

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- en_i  in  1  consumer enable; when low, ready_o is driven low from the next edge
- clr_i  in  1  synchronous clear of counters, flags and expected value
- valid_i  in  1  upstream beat valid
- data_i  in  DW  upstream beat data
- ready_o  out  1  registered ready to upstream
- exp_data_o  out  DW  value expected for the next beat
- beat_cnt_o  out  CW  accepted beats, saturating
- err_cnt_o  out  CW  data mismatches, saturating
- err_o  out  1  sticky flag: at least one data mismatch
- err_data_o  out  DW  received data of the most recent mismatch
- proto_o  out  1  sticky flag: handshake protocol violation

Behaviour:
- Reset (rst=0, asynchronous) values:
  - ready_o=0, gap counter=0
  - beat_cnt_o=0, err_cnt_o=0
  - err_o=0, proto_o=0, err_data_o=0
  - exp_data_o=INIT
- Accept condition: acc = valid_i & ready_o, sampled at the rising edge.
- Backpressure (ready_o is registered):
  - Gap counter gcnt has width clog2(DELAY+1), minimum 1.
  - On acc with DELAY>0: gcnt<=DELAY, ready_o<=0.
  - While gcnt>0: gcnt decrements; ready_o<=en_i & (gcnt==1).
  - Otherwise: ready_o<=en_i.
  - Result: after an accept at edge t, ready_o is low during cycles t+1..t+DELAY and high again from edge t+DELAY+1 (if en_i=1).
  - With DELAY=0 and en_i=1, ready_o stays high continuously; one beat per cycle.
  - en_i low does not pause gcnt.
- Data check on acc:
  - Match (data_i==exp_data_o): beat_cnt_o increments (saturates at 2^CW-1); exp_data_o<=exp_data_o+1, modulo 2^DW (wraps 2^DW-1 -> 0).
  - Mismatch: beat_cnt_o and err_cnt_o increment (both saturate); err_o<=1; err_data_o<=data_i; exp_data_o<=data_i+1, modulo 2^DW, so a single dropped beat yields exactly one error.
- Protocol check uses registered copies of the previous cycle's valid_i & ~ready_o and data_i.
  - Previous cycle valid_i=1 with ready_o=0, and this cycle valid_i=0 or data_i changed: proto_o<=1 (sticky).
  - Checked only while rst is released; both registers are cleared by rst and clr_i.
- clr_i=1 (synchronous):
  - Clears beat_cnt_o, err_cnt_o, err_o, err_data_o and proto_o.
  - Sets exp_data_o<=INIT.
  - clr_i has priority over a simultaneous acc: the beat completes the handshake but is not counted or checked.
  - clr_i does not affect ready_o or gcnt.
- Reset mid-gap: the gap is abandoned; ready_o=0 during reset and rises on the first edge after release if en_i=1.

Decomposition:
- Package stream_chk_pkg:
  - Localparam function for the gap-counter width (clog2 with minimum 1).
  - Typedef for the CW-wide saturating counter.
  - Saturating-increment function.
- Sub-module backpressure_ctrl (params DELAY; ports clk, rst, en_i, acc_i, ready_o) owns gcnt and ready_o.
- The top holds the scoreboard, counters and protocol monitor.

Test Plan:
- Reset release, DELAY=0, en_i=1; generator sends 0,1,2,...,9 back-to-back -> ready_o high from first edge; beat_cnt_o=10, err_cnt_o=0, exp_data_o=10, err_o=0.
- DELAY=3; 4 beats 0..3, valid_i held high -> ready_o pattern 1,0,0,0,1 per beat; accepts spaced 4 cycles; beat_cnt_o=4, no errors.
- DW=4, INIT=14; beats 14,15,0,1 -> no errors, exp_data_o wraps to 2. Then send 5 (skipping 2..4) -> err_cnt_o=1, err_data_o=5, exp_data_o=6. Then send 6 -> no new error.
- Upstream raises valid_i with data 7 while ready_o=0 (en_i=0), drops valid_i next cycle -> proto_o=1. Repeat with data changing 7->8 -> proto_o stays 1.
- clr_i pulsed in the same cycle as an accepted mismatching beat, with err_cnt_o=2 -> counters 0, err_o=0, exp_data_o=INIT; the beat is not counted.
- rst asserted during a DELAY=5 gap -> outputs return to reset values immediately. After release, ready_o=1 one edge later; a beat of INIT is accepted without error.

Source files
------------

// File: rtl/stream_chk_pkg.sv
// Shared types and helpers for the stream checker.
package stream_chk_pkg;

  localparam int unsigned CNT_MAX_W = 64;

  // Widest counter the helpers handle; narrower counters are cast in and out.
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // Gap-counter width: enough bits to hold DELAY, never less than one bit.
  function automatic int unsigned gap_w(input int unsigned delay);
    return (delay == 0) ? 32'd1 : 32'($clog2(delay + 1));
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic cnt_t sat_inc(input cnt_t v, input int unsigned w);
    cnt_t max_v;
    max_v = (w >= CNT_MAX_W) ? {CNT_MAX_W{1'b1}} : ((cnt_t'(1) << w) - cnt_t'(1));
    return (v >= max_v) ? max_v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/backpressure_ctrl.sv
// Registered ready generator: DELAY idle cycles after every accepted beat.
module backpressure_ctrl
  import stream_chk_pkg::*;
#(
  parameter int unsigned DELAY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic acc_i,
  output logic ready_o
);

  localparam int unsigned GW = gap_w(DELAY);

  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          ready_q, ready_d;

  // Next gap count and ready; the gap keeps counting even while en_i is low.
  always_comb begin
    gcnt_d  = gcnt_q;
    ready_d = en_i;
    if (acc_i && (DELAY > 0)) begin
      gcnt_d  = GW'(DELAY);
      ready_d = 1'b0;
    end else if (gcnt_q != '0) begin
      gcnt_d  = gcnt_q - GW'(1);
      ready_d = en_i & (gcnt_q == GW'(1));
    end
  end

  // State registers; reset abandons any gap in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      gcnt_q  <= gcnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/stream_checker.sv
// Stream sink: checks beats against an incrementing reference, counts beats and
// mismatches, and watches the upstream for handshake violations.
module stream_checker
  import stream_chk_pkg::*;
#(
  parameter int unsigned    DW    = 16,
  parameter int unsigned    DELAY = 0,
  parameter logic [DW-1:0]  INIT  = '0,
  parameter int unsigned    CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic [DW-1:0] exp_data_o,
  output logic [CW-1:0] beat_cnt_o,
  output logic [CW-1:0] err_cnt_o,
  output logic          err_o,
  output logic [DW-1:0] err_data_o,
  output logic          proto_o
);

  logic          acc;
  logic [DW-1:0] exp_q, exp_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] errc_q, errc_d;
  logic          err_q, err_d;
  logic [DW-1:0] errd_q, errd_d;
  logic          proto_q, proto_d;
  logic          stall_q, stall_d;
  logic [DW-1:0] pdata_q, pdata_d;

  assign acc = valid_i & ready_o;

  backpressure_ctrl #(.DELAY(DELAY)) u_bp (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .acc_i   (acc),
    .ready_o (ready_o)
  );

  // Scoreboard and protocol monitor next state; clear wins over an accept.
  always_comb begin
    exp_d   = exp_q;
    beat_d  = beat_q;
    errc_d  = errc_q;
    err_d   = err_q;
    errd_d  = errd_q;
    proto_d = proto_q;
    stall_d = valid_i & ~ready_o;
    pdata_d = data_i;
    if (clr_i) begin
      exp_d   = INIT;
      beat_d  = '0;
      errc_d  = '0;
      err_d   = 1'b0;
      errd_d  = '0;
      proto_d = 1'b0;
      stall_d = 1'b0;
      pdata_d = '0;
    end else begin
      if (acc) begin
        beat_d = CW'(sat_inc(cnt_t'(beat_q), CW));
        if (data_i == exp_q) begin
          exp_d = exp_q + DW'(1);
        end else begin
          // Resync on the received value so one dropped beat costs one error.
          errc_d = CW'(sat_inc(cnt_t'(errc_q), CW));
          err_d  = 1'b1;
          errd_d = data_i;
          exp_d  = data_i + DW'(1);
        end
      end
      // A stalled beat must stay valid with unchanged data.
      if (stall_q && (!valid_i || (data_i != pdata_q))) begin
        proto_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q   <= INIT;
      beat_q  <= '0;
      errc_q  <= '0;
      err_q   <= 1'b0;
      errd_q  <= '0;
      proto_q <= 1'b0;
      stall_q <= 1'b0;
      pdata_q <= '0;
    end else begin
      exp_q   <= exp_d;
      beat_q  <= beat_d;
      errc_q  <= errc_d;
      err_q   <= err_d;
      errd_q  <= errd_d;
      proto_q <= proto_d;
      stall_q <= stall_d;
      pdata_q <= pdata_d;
    end
  end

  assign exp_data_o = exp_q;
  assign beat_cnt_o = beat_q;
  assign err_cnt_o  = errc_q;
  assign err_o      = err_q;
  assign err_data_o = errd_q;
  assign proto_o    = proto_q;

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: directed scenarios plus random traffic against a
// transaction-level reference model. Instance 0: DW=16 DELAY=0 INIT=0 CW=32.
// Instance 1: DW=4 DELAY=3 INIT=14 CW=4 (exercises wrap and saturation).
module tb_stream_checker;

  logic        clk;
  logic        rst;
  logic        en[2];
  logic        clr[2];
  logic        valid[2];
  logic [15:0] data[2];

  logic [15:0] a_exp, a_errd;
  logic [31:0] a_beat, a_errc;
  logic        a_rdy, a_err, a_proto;
  logic [3:0]  b_exp, b_errd, b_beat, b_errc;
  logic        b_rdy, b_err, b_proto;

  logic [31:0] o_exp[2], o_beat[2], o_errc[2], o_errd[2];
  logic        o_rdy[2], o_err[2], o_proto[2];

  int checks;
  int errors;

  int unsigned cfg_dw[2]   = '{16, 4};
  int unsigned cfg_dly[2]  = '{0, 3};
  int unsigned cfg_init[2] = '{0, 14};
  int unsigned cfg_max[2]  = '{32'hFFFF_FFFF, 15};

  // Reference model state
  int unsigned m_exp[2], m_beat[2], m_errc[2], m_errd[2], m_since[2], m_sdata[2];
  bit          m_err[2], m_proto[2], m_rdy[2], m_stall[2];

  stream_checker #(.DW(16), .DELAY(0), .INIT(16'd0), .CW(32)) dut_a (
    .clk(clk), .rst(rst), .en_i(en[0]), .clr_i(clr[0]), .valid_i(valid[0]),
    .data_i(data[0]), .ready_o(a_rdy), .exp_data_o(a_exp), .beat_cnt_o(a_beat),
    .err_cnt_o(a_errc), .err_o(a_err), .err_data_o(a_errd), .proto_o(a_proto)
  );

  stream_checker #(.DW(4), .DELAY(3), .INIT(4'd14), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .en_i(en[1]), .clr_i(clr[1]), .valid_i(valid[1]),
    .data_i(data[1][3:0]), .ready_o(b_rdy), .exp_data_o(b_exp), .beat_cnt_o(b_beat),
    .err_cnt_o(b_errc), .err_o(b_err), .err_data_o(b_errd), .proto_o(b_proto)
  );

  always_comb begin
    o_exp[0] = 32'(a_exp);   o_exp[1] = 32'(b_exp);
    o_beat[0] = a_beat;      o_beat[1] = 32'(b_beat);
    o_errc[0] = a_errc;      o_errc[1] = 32'(b_errc);
    o_errd[0] = 32'(a_errd); o_errd[1] = 32'(b_errd);
    o_rdy[0] = a_rdy;        o_rdy[1] = b_rdy;
    o_err[0] = a_err;        o_err[1] = b_err;
    o_proto[0] = a_proto;    o_proto[1] = b_proto;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = cfg_init[i]; m_beat[i] = 0; m_errc[i] = 0; m_errd[i] = 0;
      m_err[i] = 0; m_proto[i] = 0; m_rdy[i] = 0; m_stall[i] = 0; m_sdata[i] = 0;
      m_since[i] = cfg_dly[i];
    end
  endtask

  // One clock of the transaction model for instance i.
  task automatic model_update(input int i);
    int unsigned mask, d;
    bit acc;
    mask = (cfg_dw[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[i]) - 1);
    d = 32'(data[i]) & mask;
    acc = valid[i] & m_rdy[i];
    if (clr[i]) begin
      m_exp[i] = cfg_init[i]; m_beat[i] = 0; m_errc[i] = 0; m_err[i] = 0;
      m_errd[i] = 0; m_proto[i] = 0; m_stall[i] = 0; m_sdata[i] = 0;
    end else begin
      if (acc) begin
        if (m_beat[i] != cfg_max[i]) m_beat[i]++;
        if (d == m_exp[i]) m_exp[i] = (m_exp[i] + 1) & mask;
        else begin
          if (m_errc[i] != cfg_max[i]) m_errc[i]++;
          m_err[i] = 1; m_errd[i] = d; m_exp[i] = (d + 1) & mask;
        end
      end
      if (m_stall[i] && (!valid[i] || d != m_sdata[i])) m_proto[i] = 1;
      m_stall[i] = valid[i] && !m_rdy[i];
      m_sdata[i] = d;
    end
    // ready: low for DELAY cycles after each accept, otherwise follows en
    if (acc && cfg_dly[i] > 0) m_since[i] = 0;
    else if (m_since[i] < cfg_dly[i]) m_since[i]++;
    m_rdy[i] = en[i] && (m_since[i] >= cfg_dly[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  // Present a beat and hold it until the DUT's ready accepts it.
  task automatic send_beat(input int i, input int unsigned v, output int cyc);
    bit done;
    bit r;
    valid[i] = 1'b1; data[i] = 16'(v); cyc = 0; done = 0;
    while (!done) begin
      r = o_rdy[i];
      step();
      cyc++;
      if (r) done = 1;
      else if (cyc >= 50) begin
        checks++; errors++;
        $display("FAIL send_timeout inst%0d got no accept want accept within 50", i);
        done = 1;
      end
    end
    valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_rdy[i] !== 1'b0) begin errors++; $display("FAIL rst_ready inst%0d got %0b want 0", i, o_rdy[i]); end
      checks++; if (o_exp[i] !== cfg_init[i]) begin errors++; $display("FAIL rst_exp inst%0d got %0d want %0d", i, o_exp[i], cfg_init[i]); end
      checks++; if (o_beat[i] !== 0 || o_errc[i] !== 0) begin errors++; $display("FAIL rst_cnt inst%0d got %0d/%0d want 0/0", i, o_beat[i], o_errc[i]); end
      checks++; if (o_err[i] !== 1'b0 || o_proto[i] !== 1'b0 || o_errd[i] !== 0) begin errors++; $display("FAIL rst_flags inst%0d got %0b%0b/%0d want 00/0", i, o_err[i], o_proto[i], o_errd[i]); end
    end
    en[0] = 1'b1; en[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b%0b want 11", a_rdy, b_rdy); end
  endtask

  task automatic test_stream();
    int c, tot;
    tot = 0;
    for (int k = 0; k < 10; k++) begin send_beat(0, k, c); tot += c; end
    checks++; if (tot != 10) begin errors++; $display("FAIL stream_cycles got %0d want 10", tot); end
    checks++; if (a_beat !== 10 || a_errc !== 0) begin errors++; $display("FAIL stream_cnt got %0d/%0d want 10/0", a_beat, a_errc); end
    checks++; if (a_exp !== 10 || a_err !== 1'b0) begin errors++; $display("FAIL stream_exp got %0d/%0b want 10/0", a_exp, a_err); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL stream_ready got %0b want 1", a_rdy); end
  endtask

  task automatic test_gap_wrap();
    int c;
    int unsigned vals[4] = '{14, 15, 0, 1};
    for (int k = 0; k < 4; k++) begin
      send_beat(1, vals[k], c);
      checks++; if (c != ((k == 0) ? 1 : 4)) begin errors++; $display("FAIL gap_spacing beat%0d got %0d want %0d", k, c, (k == 0) ? 1 : 4); end
    end
    checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL gap_ready_low got %0b want 0", b_rdy); end
    checks++; if (b_exp !== 4'd2 || b_errc !== 4'd0 || b_beat !== 4'd4) begin errors++; $display("FAIL wrap_state got exp%0d err%0d beat%0d want 2/0/4", b_exp, b_errc, b_beat); end
    send_beat(1, 5, c);
    checks++; if (b_errc !== 4'd1 || b_errd !== 4'd5 || b_exp !== 4'd6 || b_err !== 1'b1) begin errors++; $display("FAIL skip_err got cnt%0d data%0d exp%0d flag%0b want 1/5/6/1", b_errc, b_errd, b_exp, b_err); end
    send_beat(1, 6, c);
    checks++; if (b_errc !== 4'd1 || b_exp !== 4'd7 || b_beat !== 4'd6) begin errors++; $display("FAIL resync got cnt%0d exp%0d beat%0d want 1/7/6", b_errc, b_exp, b_beat); end
  endtask

  task automatic test_protocol();
    en[0] = 1'b0; step();
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL proto_en_low_ready got %0b want 0", a_rdy); end
    valid[0] = 1'b1; data[0] = 16'd7; step();
    valid[0] = 1'b0; step();
    checks++; if (a_proto !== 1'b1) begin errors++; $display("FAIL proto_drop got %0b want 1", a_proto); end
    valid[0] = 1'b1; data[0] = 16'd7; step();
    data[0] = 16'd8; step();
    valid[0] = 1'b0;
    checks++; if (a_proto !== 1'b1) begin errors++; $display("FAIL proto_sticky got %0b want 1", a_proto); end
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    checks++; if (a_proto !== 1'b0 || a_beat !== 0 || a_exp !== 0) begin errors++; $display("FAIL proto_clr got %0b/%0d/%0d want 0/0/0", a_proto, a_beat, a_exp); end
    // Legal stall: held with stable data until accepted.
    valid[0] = 1'b1; data[0] = 16'd0; step(); step();
    en[0] = 1'b1; step(); step();
    valid[0] = 1'b0;
    checks++; if (a_proto !== 1'b0 || a_beat !== 1) begin errors++; $display("FAIL proto_legal_stall got %0b/%0d want 0/1", a_proto, a_beat); end
    en[0] = 1'b0; step();
    valid[0] = 1'b1; data[0] = 16'd7; step();
    data[0] = 16'd8; step();
    valid[0] = 1'b0;
    checks++; if (a_proto !== 1'b1) begin errors++; $display("FAIL proto_data_change got %0b want 1", a_proto); end
    clr[0] = 1'b1; en[0] = 1'b1; step(); clr[0] = 1'b0;
  endtask

  task automatic test_clear();
    int c;
    int n;
    send_beat(1, 0, c);
    checks++; if (b_errc !== 4'd2) begin errors++; $display("FAIL clr_pre got %0d want 2", b_errc); end
    n = 0;
    while (b_rdy !== 1'b1 && n < 20) begin step(); n++; end
    valid[1] = 1'b1; data[1] = 16'd9; clr[1] = 1'b1; step();
    valid[1] = 1'b0; clr[1] = 1'b0;
    checks++; if (b_beat !== 0 || b_errc !== 0 || b_err !== 1'b0 || b_errd !== 0) begin errors++; $display("FAIL clr_counters got %0d/%0d/%0b/%0d want 0/0/0/0", b_beat, b_errc, b_err, b_errd); end
    checks++; if (b_exp !== 4'd14) begin errors++; $display("FAIL clr_exp got %0d want 14", b_exp); end
    checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL clr_gap_ready got %0b want 0", b_rdy); end
  endtask

  task automatic test_saturation();
    int c;
    int unsigned cur, d;
    cur = 14;
    for (int k = 0; k < 17; k++) begin send_beat(1, cur, c); cur = (cur + 1) % 16; end
    checks++; if (b_beat !== 4'd15 || b_errc !== 4'd0) begin errors++; $display("FAIL sat_beat got %0d/%0d want 15/0", b_beat, b_errc); end
    for (int k = 0; k < 17; k++) begin d = (cur + 1) % 16; send_beat(1, d, c); cur = (d + 1) % 16; end
    checks++; if (b_errc !== 4'd15 || b_beat !== 4'd15 || 32'(b_exp) !== cur) begin errors++; $display("FAIL sat_err got %0d/%0d/%0d want 15/15/%0d", b_errc, b_beat, b_exp, cur); end
  endtask

  task automatic test_reset_mid_gap();
    int c;
    send_beat(1, m_exp[1], c);
    #2 rst = 1'b0;
    #1;
    checks++; if (b_rdy !== 1'b0 || b_exp !== 4'd14 || b_beat !== 0 || b_errc !== 0) begin errors++; $display("FAIL midgap_rst got %0b/%0d/%0d/%0d want 0/14/0/0", b_rdy, b_exp, b_beat, b_errc); end
    checks++; if (b_err !== 1'b0 || b_proto !== 1'b0 || b_errd !== 0 || a_beat !== 0) begin errors++; $display("FAIL midgap_flags got %0b/%0b/%0d/%0d want 0/0/0/0", b_err, b_proto, b_errd, a_beat); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL midgap_release_ready got %0b want 1", b_rdy); end
    send_beat(1, 14, c);
    checks++; if (c != 1 || b_err !== 1'b0 || b_beat !== 4'd1 || b_exp !== 4'd15) begin errors++; $display("FAIL midgap_beat got c%0d %0b/%0d/%0d want 1 0/1/15", c, b_err, b_beat, b_exp); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]    = ($urandom_range(0, 7) != 0);
        clr[i]   = ($urandom_range(0, 63) == 0);
        valid[i] = ($urandom_range(0, 2) != 0);
        data[i]  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'(m_exp[i]);
      end
      step();
      for (int i = 0; i < 2; i++) begin
        checks++; if (o_rdy[i] !== m_rdy[i]) begin errors++; $display("FAIL rnd_ready inst%0d cyc%0d got %0b want %0b", i, n, o_rdy[i], m_rdy[i]); end
        checks++; if (o_exp[i] !== m_exp[i]) begin errors++; $display("FAIL rnd_exp inst%0d cyc%0d got %0d want %0d", i, n, o_exp[i], m_exp[i]); end
        checks++; if (o_beat[i] !== m_beat[i]) begin errors++; $display("FAIL rnd_beat inst%0d cyc%0d got %0d want %0d", i, n, o_beat[i], m_beat[i]); end
        checks++; if (o_errc[i] !== m_errc[i]) begin errors++; $display("FAIL rnd_errcnt inst%0d cyc%0d got %0d want %0d", i, n, o_errc[i], m_errc[i]); end
        checks++; if (o_err[i] !== m_err[i]) begin errors++; $display("FAIL rnd_err inst%0d cyc%0d got %0b want %0b", i, n, o_err[i], m_err[i]); end
        checks++; if (o_errd[i] !== m_errd[i]) begin errors++; $display("FAIL rnd_errdata inst%0d cyc%0d got %0d want %0d", i, n, o_errd[i], m_errd[i]); end
        checks++; if (o_proto[i] !== m_proto[i]) begin errors++; $display("FAIL rnd_proto inst%0d cyc%0d got %0b want %0b", i, n, o_proto[i], m_proto[i]); end
      end
    end
    for (int i = 0; i < 2; i++) begin valid[i] = 1'b0; clr[i] = 1'b0; end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; clr[i] = 1'b0; valid[i] = 1'b0; data[i] = '0;
    end
    model_reset();
    test_reset();
    test_stream();
    test_gap_wrap();
    test_protocol();
    test_clear();
    test_saturation();
    test_reset_mid_gap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
